ioctl_region_loader: RTL

//  Routes data_io ROM download bytes into NREG SDRAM write ports, each with its own address window.
//  - Packs byte pairs into 16-bit words with byte-enables; buffers them in a small FIFO.
//  - Issues one toggle-req/ack write at a time; signals rom_loaded when everything has drained.
//  - Sits between data_io and the sdram controller in every arcade top level, replacing hand-wired per-port req toggles.

---
 rtl/ioctl_loader_pkg.sv | 28 ++
 rtl/ioctl_region_loader_fifo.sv | 49 ++++
 rtl/ioctl_region_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared types for the ioctl region loader: FIFO word entry, drain FSM states
// and the per-region address window test.
package ioctl_loader_pkg;

  // Sized for up to 8 regions and a 23-bit SDRAM word address.
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned WADDR_W = 23;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [WADDR_W-1:0] waddr;
    logic [15:0]        data;
    logic [1:0]         ds;
  } word_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } drain_state_t;

  function automatic logic region_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] last);
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/ioctl_region_loader_fifo.sv
// Synchronous FIFO for packed loader words; a push into a full FIFO is
// honoured only when a pop happens in the same cycle.
module loader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ioctl_region_loader.sv
// Routes data_io ROM download bytes into NREG toggle-handshake SDRAM write
// ports, packing byte pairs into words and draining them one at a time.
module ioctl_region_loader
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned         NREG       = 4,
  parameter int unsigned         AW         = 25,
  parameter int unsigned         WAW        = 23,
  parameter logic [7:0]          ROM_INDEX  = 8'h00,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [NREG*AW-1:0]  BASE       = '0,
  parameter logic [NREG*AW-1:0]  LAST       = '0
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ioctl_downl,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [AW-1:0]   ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic [NREG-1:0] port_req,
  input  logic [NREG-1:0] port_ack,
  output logic [WAW-1:0]  port_a,
  output logic [15:0]     port_d,
  output logic [1:0]      port_ds,
  output logic            rom_loaded,
  output logic            hold_reset,
  output logic            overflow,
  output logic            unmapped
);

  logic               rom_dl;
  logic               rom_dl_prev;
  logic               rom_dl_seen;
  logic               accept;
  logic               hit;
  logic [IDX_W-1:0]   hit_r;
  logic [AW-1:0]      diff;
  logic [WADDR_W-1:0] byte_waddr;
  logic               same_word;

  logic               pend_valid;
  logic [IDX_W-1:0]   pend_r;
  logic [WADDR_W-1:0] pend_waddr;
  logic [7:0]         pend_data;
  logic               defer_valid;
  word_entry_t        defer_entry;

  logic               push;
  word_entry_t        push_entry;
  word_entry_t        flush_entry;
  logic               defer_set;
  word_entry_t        defer_next;
  logic               pend_load;
  logic               pend_clear;
  logic               unmapped_set;
  logic               loaded_cond;

  word_entry_t        head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               load;
  logic               toggle;
  logic               head_idle;
  logic               cur_done;
  logic [IDX_W-1:0]   cur_r;
  drain_state_t       state;
  drain_state_t       state_next;

  assign rom_dl     = ioctl_downl & (ioctl_index == ROM_INDEX);
  assign accept     = ioctl_wr & rom_dl;
  assign byte_waddr = WADDR_W'(diff >> 1);
  assign same_word  = pend_valid && (pend_r == hit_r) && (pend_waddr == byte_waddr);
  assign hold_reset = reset | ioctl_downl | ~rom_loaded;
  assign loaded_cond = rom_dl_seen & ~ioctl_downl & ~pend_valid & ~defer_valid &
                       fifo_empty & (state == IDLE);

  always_comb begin
    hit   = 1'b0;
    hit_r = '0;
    diff  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (!hit && region_match(32'(ioctl_addr), 32'(BASE[r*AW +: AW]), 32'(LAST[r*AW +: AW]))) begin
        hit   = 1'b1;
        hit_r = IDX_W'(r);
        diff  = ioctl_addr - BASE[r*AW +: AW];
      end
    end
  end

  // A flush and the new odd byte both need a FIFO slot; the flush goes first and
  // the odd byte is parked in defer_entry for the next cycle (strobes are >=4 clk apart).
  always_comb begin
    push         = 1'b0;
    push_entry   = '0;
    defer_set    = 1'b0;
    defer_next   = '0;
    pend_load    = 1'b0;
    pend_clear   = 1'b0;
    unmapped_set = 1'b0;
    flush_entry  = '{idx: pend_r, waddr: pend_waddr, data: {8'h00, pend_data}, ds: 2'b01};
    if (defer_valid) begin
      push       = 1'b1;
      push_entry = defer_entry;
    end else if (!ioctl_downl && pend_valid) begin
      push       = 1'b1;
      push_entry = flush_entry;
      pend_clear = 1'b1;
    end
    if (accept) begin
      if (!hit) begin
        unmapped_set = 1'b1;
      end else if (!ioctl_addr[0]) begin
        pend_load = 1'b1;
        if (pend_valid) begin
          push       = 1'b1;
          push_entry = flush_entry;
        end
      end else if (same_word) begin
        push       = 1'b1;
        push_entry = '{idx: hit_r, waddr: byte_waddr, data: {ioctl_dout, pend_data}, ds: 2'b11};
        pend_clear = 1'b1;
      end else if (pend_valid) begin
        push       = 1'b1;
        push_entry = flush_entry;
        pend_clear = 1'b1;
        defer_set  = 1'b1;
        defer_next = '{idx: hit_r, waddr: byte_waddr, data: {ioctl_dout, 8'h00}, ds: 2'b10};
      end else begin
        push       = 1'b1;
        push_entry = '{idx: hit_r, waddr: byte_waddr, data: {ioctl_dout, 8'h00}, ds: 2'b10};
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_r      <= '0;
      pend_waddr  <= '0;
      pend_data   <= '0;
      defer_valid <= 1'b0;
      defer_entry <= '0;
      rom_dl_prev <= 1'b0;
      rom_dl_seen <= 1'b0;
      rom_loaded  <= 1'b0;
      overflow    <= 1'b0;
      unmapped    <= 1'b0;
    end else begin
      rom_dl_prev <= rom_dl;
      defer_valid <= defer_set;
      if (defer_set) defer_entry <= defer_next;
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_r     <= hit_r;
        pend_waddr <= byte_waddr;
        pend_data  <= ioctl_dout;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end
      if (rom_dl && !rom_dl_prev) begin
        rom_dl_seen <= 1'b1;
        rom_loaded  <= 1'b0;
        overflow    <= 1'b0;
        unmapped    <= 1'b0;
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (unmapped_set) unmapped <= 1'b1;
      if (loaded_cond) rom_loaded <= 1'b1;
    end
  end

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (word_entry_t)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    head_idle = 1'b0;
    cur_done  = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (IDX_W'(r) == head.idx) head_idle = (port_req[r] == port_ack[r]);
      if (IDX_W'(r) == cur_r)    cur_done  = (port_req[r] == port_ack[r]);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    toggle     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && head_idle) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        toggle     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cur_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port_req <= '0;
      port_a   <= '0;
      port_d   <= '0;
      port_ds  <= '0;
      cur_r    <= '0;
    end else begin
      if (load) begin
        port_a  <= WAW'(head.waddr);
        port_d  <= head.data;
        port_ds <= head.ds;
        cur_r   <= head.idx;
      end
      if (toggle) begin
        for (int unsigned r = 0; r < NREG; r++) begin
          if (IDX_W'(r) == cur_r) port_req[r] <= ~port_req[r];
        end
      end
    end
  end

endmodule
